// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock ratio monitor.
package clk_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EDGE,
        ACQUIRE,
        LOCKED,
        FAULT
    } state_t;

    localparam int ERR_CNT_W = 16;

    // States in which the period counter runs and measured periods are judged.
    function automatic logic is_measuring(input state_t s);
        return (s == ACQUIRE) || (s == LOCKED) || (s == FAULT);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer bringing an asynchronous level into the clk domain.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync <= '0;
        else     sync <= {sync[STAGES-2:0], d};
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/clk_ratio_monitor.sv
// Measures the period of a divided clock in clk cycles and reports lock/fault against DIV_RATIO.
// Define CLK_MON_STATS_EN to add the saturating err_cnt statistics counter and port.
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int DIV_RATIO   = 4,
    parameter int TOL         = 0,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clk_in,
    input  logic                 en,
    output logic                 locked,
    output logic                 fault,
    output logic [CNT_W-1:0]     period,
    output logic                 period_vld
`ifdef CLK_MON_STATS_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    localparam int GC_W = $clog2(LOCK_CNT + 1);
    localparam int LO_I = (DIV_RATIO > TOL) ? DIV_RATIO - TOL : 0;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(2 * DIV_RATIO);
    localparam logic [CNT_W-1:0] GOOD_LO     = CNT_W'(LO_I);
    localparam logic [CNT_W-1:0] GOOD_HI     = CNT_W'(DIV_RATIO + TOL);
    localparam logic [GC_W-1:0]  GC_LOCK     = GC_W'(LOCK_CNT);
    localparam logic [GC_W-1:0]  GC_ONE      = GC_W'(1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [GC_W-1:0]   good_cnt, gc_nxt, gc_inc;
    logic              clk_in_s, clk_in_prev, rise;
    logic              active, good, timeout, ev_good, ev_bad;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (clk_in),
        .q   (clk_in_s)
    );

    assign rise    = clk_in_s & ~clk_in_prev;
    assign active  = is_measuring(state);
    assign good    = (cnt >= GOOD_LO) && (cnt <= GOOD_HI);
    // An edge in the timeout cycle takes precedence; the period itself is then judged.
    assign timeout = active && !rise && (cnt == TIMEOUT_VAL);
    assign ev_good = active && rise && good;
    assign ev_bad  = (active && rise && !good) || timeout;
    assign gc_inc  = good_cnt + GC_ONE;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gc_nxt    = good_cnt;
        if (!en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            gc_nxt    = '0;
        end else begin
            if (active) begin
                if (rise)                cnt_nxt = CNT_W'(1);
                else if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
            end
            unique case (state)
                IDLE:      state_nxt = WAIT_EDGE;
                WAIT_EDGE: begin
                    if (rise) begin
                        state_nxt = ACQUIRE;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
                ACQUIRE: begin
                    if (ev_good) begin
                        gc_nxt = gc_inc;
                        if (gc_inc == GC_LOCK) state_nxt = LOCKED;
                    end else if (ev_bad) begin
                        gc_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (ev_bad) begin
                        state_nxt = FAULT;
                        gc_nxt    = '0;
                    end
                end
                FAULT: begin
                    if (ev_good) begin
                        state_nxt = ACQUIRE;
                        gc_nxt    = GC_ONE;
                    end
                end
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            good_cnt    <= '0;
            clk_in_prev <= 1'b0;
            period      <= '0;
            period_vld  <= 1'b0;
            locked      <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            good_cnt    <= gc_nxt;
            clk_in_prev <= clk_in_s;
            period_vld  <= en && active && rise;
            if (en && active && rise) period <= cnt;
            locked      <= (state_nxt == LOCKED);
            fault       <= (state_nxt == FAULT);
        end
    end

`ifdef CLK_MON_STATS_EN
    // Cleared only by rst so statistics survive enable toggles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     err_cnt <= '0;
        else if (en && ev_bad && (err_cnt != '1))    err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Self-checking bench for clk_ratio_monitor: period vectors table plus period scoreboard.
module tb_clk_ratio_monitor;

    typedef struct {
        bit rise;        // drive a clk_in rising edge at the start of this slot
        int len;         // slot length in clk cycles
        int exp_period;  // period reported by this edge, 0 = no report expected
        bit exp_locked;  // at end of slot
        bit exp_fault;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_in = 1'b0;
    logic       en = 1'b0;
    logic       locked0, fault0, vld0, locked_t, fault_t, vld_t;
    logic [7:0] period0, period_t;
`ifdef CLK_MON_STATS_EN
    logic [15:0] err0, err_t, cur_err;
`endif

    logic       sel = 1'b0;
    logic       cur_locked, cur_fault, cur_vld;
    logic [7:0] cur_period;

    int n_pass = 0;
    int n_total = 0;
    int sb_q[$];
    int exp_p;
    vec_t vq[$];

    always #5 clk = ~clk;

    clk_ratio_monitor dut0 (
        .clk(clk), .rst(rst), .clk_in(clk_in), .en(en),
        .locked(locked0), .fault(fault0), .period(period0), .period_vld(vld0)
`ifdef CLK_MON_STATS_EN
        , .err_cnt(err0)
`endif
    );

    clk_ratio_monitor #(.TOL(1)) dut_t (
        .clk(clk), .rst(rst), .clk_in(clk_in), .en(en),
        .locked(locked_t), .fault(fault_t), .period(period_t), .period_vld(vld_t)
`ifdef CLK_MON_STATS_EN
        , .err_cnt(err_t)
`endif
    );

    assign cur_locked = sel ? locked_t : locked0;
    assign cur_fault  = sel ? fault_t  : fault0;
    assign cur_vld    = sel ? vld_t    : vld0;
    assign cur_period = sel ? period_t : period0;
`ifdef CLK_MON_STATS_EN
    assign cur_err    = sel ? err_t    : err0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every period_vld must match the oldest expected period.
    always @(negedge clk) begin
        if (!rst && cur_vld) begin
            if (sb_q.size() == 0) begin
                check("vld_with_empty_scoreboard", int'(cur_vld), 0);
            end else begin
                exp_p = sb_q.pop_front();
                check("period", int'(cur_period), exp_p);
            end
        end
    end

    task automatic add(input bit r, input int len, input int ep, input bit el, input bit ef);
        vec_t v;
        v.rise = r; v.len = len; v.exp_period = ep; v.exp_locked = el; v.exp_fault = ef;
        vq.push_back(v);
    endtask

    // Called at a negedge; returns at the negedge ending the slot.
    task automatic run_vec(input vec_t v, input string tag, input int idx);
        int hi;
        hi = !v.rise ? 0 : ((v.len >= 4) ? 2 : 1);
        if (v.rise) begin
            if (v.exp_period != 0) sb_q.push_back(v.exp_period);
            clk_in = 1'b1;
        end
        for (int i = 0; i < v.len; i++) begin
            @(negedge clk);
            if (i + 1 == hi) clk_in = 1'b0;
        end
        check($sformatf("%s[%0d].locked", tag, idx), int'(cur_locked), int'(v.exp_locked));
        check($sformatf("%s[%0d].fault", tag, idx), int'(cur_fault), int'(v.exp_fault));
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) run_vec(vq[i], tag, i);
        vq.delete();
    endtask

    task automatic do_reset();
        check("sb_drained_before_rst", sb_q.size(), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async.locked", int'(cur_locked), 0);
        check("rst_async.fault", int'(cur_fault), 0);
        check("rst_async.period", int'(cur_period), 0);
        en = 1'b0;
        clk_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
    endtask

    initial begin
        #1;
        check("reset.locked", int'(locked0), 0);
        check("reset.fault", int'(fault0), 0);
        check("reset.period", int'(period0), 0);
        check("reset.vld", int'(vld0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en = 1'b1;

        // Steady clk/4: lock after four good periods, then a stretched period, relock,
        // then a stall: timeout at counter 8 and a saturated late edge.
        add(1, 4, 0, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 1, 0);
        add(1, 6, 4, 1, 0);
        add(1, 4, 6, 0, 1);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 1, 0);
        add(1, 10, 4, 1, 0);
        add(0, 1, 0, 0, 1);
        add(0, 289, 0, 0, 1);
        add(1, 4, 255, 0, 1);
        add(1, 4, 4, 0, 0);
        run_table("lock_fault");

        // TOL=1 instance: 3,5,4,5 all good, 6 is bad.
        sel = 1'b1;
        do_reset();
        add(1, 3, 0, 0, 0);
        add(1, 5, 3, 0, 0);
        add(1, 4, 5, 0, 0);
        add(1, 5, 4, 0, 0);
        add(1, 6, 5, 1, 0);
        add(1, 4, 6, 0, 1);
        run_table("tol1");

        // en dropped with good_cnt=2, then a full re-acquisition.
        sel = 1'b0;
        do_reset();
        add(1, 4, 0, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        run_table("pre_disable");
        en = 1'b0;
        @(negedge clk);
        check("disable.locked", int'(cur_locked), 0);
        check("disable.fault", int'(cur_fault), 0);
        check("disable.period_hold", int'(cur_period), 4);
        check("disable.vld", int'(cur_vld), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        add(1, 4, 0, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 0, 0);
        add(1, 4, 4, 1, 0);
        run_table("reenable");

`ifdef CLK_MON_STATS_EN
        // Three bad periods then one timeout.
        do_reset();
        check("err.after_rst", int'(cur_err), 0);
        add(1, 4, 0, 0, 0);
        add(1, 6, 4, 0, 0);
        add(1, 4, 6, 0, 0);
        add(1, 6, 4, 0, 0);
        add(1, 4, 6, 0, 0);
        add(1, 6, 4, 0, 0);
        add(1, 20, 6, 0, 0);
        run_table("stats");
        check("err.count", int'(cur_err), 4);
        en = 1'b0;
        repeat (2) @(negedge clk);
        check("err.en_low", int'(cur_err), 4);
        en = 1'b1;
        repeat (2) @(negedge clk);
        check("err.en_high", int'(cur_err), 4);
        rst = 1'b1;
        #1;
        check("err.rst", int'(cur_err), 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (5) @(negedge clk);
        check("sb_empty_at_end", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
